// File: rtl/spi_read_scheduler_pkg.sv
// Shared types for the SPI read scheduler.
// Optional watchdog: define SPI_RD_TIMEOUT_EN.
package spi_rd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        BUSY,
        GAP
    } sched_state_t;

    // Smallest idle gap the engine tolerates between commands.
    localparam int GAP_MIN = 2;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_read_scheduler_if.sv
// Requester, engine and tagged-stream bundle of the SPI read scheduler.
// master = scheduler side, slave = requesters/engine side.
interface spi_read_scheduler_if
    import spi_rd_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int REG_WIDTH = 8
);
    localparam int IDW = id_width(N_REQ);

    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ*REG_WIDTH-1:0] req_addr;
    logic [N_REQ*8-1:0]         req_len;

    logic                 eng_new_command;
    logic [REG_WIDTH-1:0] eng_start_addr;
    logic [7:0]           eng_num_regs;
    logic                 eng_rstn;
    logic [REG_WIDTH-1:0] eng_data;
    logic                 eng_byte_done;
    logic                 eng_read_complete;

    logic                 rd_valid;
    logic [REG_WIDTH-1:0] rd_data;
    logic [IDW-1:0]       rd_id;
    logic                 rd_last;

    logic           done_valid;
    logic [IDW-1:0] done_id;
    logic           done_err;
    logic           busy;

    modport master (
        input  req_valid, req_addr, req_len,
        input  eng_data, eng_byte_done, eng_read_complete,
        output req_ready,
        output eng_new_command, eng_start_addr, eng_num_regs, eng_rstn,
        output rd_valid, rd_data, rd_id, rd_last,
        output done_valid, done_id, done_err, busy
    );

    modport slave (
        output req_valid, req_addr, req_len,
        output eng_data, eng_byte_done, eng_read_complete,
        input  req_ready,
        input  eng_new_command, eng_start_addr, eng_num_regs, eng_rstn,
        input  rd_valid, rd_data, rd_id, rd_last,
        input  done_valid, done_id, done_err, busy
    );

endinterface

// File: rtl/spi_read_scheduler_rr_arbiter.sv
// Round-robin arbiter: first request at/after the pointer wins.
// Pointer moves past the winner whenever a grant is taken.
module rr_arbiter
    import spi_rd_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDW  = id_width(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   idx,
    output logic             any
);
    logic [IDW-1:0] ptr;

    // Scan from the pointer, wrapping, and keep the first hit.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[(int'(ptr) + i) % N_REQ]) begin
                any = 1'b1;
                idx = IDW'((int'(ptr) + i) % N_REQ);
                gnt[(int'(ptr) + i) % N_REQ] = 1'b1;
            end
        end
    end

    // Advance the pointer to the slot after the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (idx == IDW'(N_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/spi_read_scheduler.sv
// Shares one SPI burst-read engine among N_REQ requesters.
// Define SPI_RD_TIMEOUT_EN to add the BUSY watchdog.
module spi_read_scheduler
    import spi_rd_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int REG_WIDTH   = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input logic clk,
    input logic rst,
    spi_read_scheduler_if.master bus
);
    localparam int IDW   = id_width(N_REQ);
    localparam int GAP_N = (GAP_CYCLES < GAP_MIN) ? GAP_MIN : GAP_CYCLES;
    localparam logic [7:0] GAP_LAST = 8'(GAP_N - 1);

    sched_state_t state;

    logic [N_REQ-1:0]     gnt;
    logic [IDW-1:0]       gidx;
    logic                 gany;
    logic                 accept;
    logic [REG_WIDTH-1:0] g_addr;
    logic [7:0]           g_len;

    logic [IDW-1:0]       lat_id;
    logic [REG_WIDTH-1:0] start_addr;
    logic [7:0]           num_regs;
    logic [7:0]           cnt;
    logic                 ovf;
    logic [7:0]           gcnt;
    logic                 new_cmd;
    logic                 abort_q;

    logic                 rd_valid;
    logic [REG_WIDTH-1:0] rd_data;
    logic [IDW-1:0]       rd_id;
    logic                 rd_last;
    logic                 done_valid;
    logic [IDW-1:0]       done_id;
    logic                 done_err;

    logic       take;
    logic       extra;
    logic [7:0] rcv_next;
    logic       burst_err;

`ifdef SPI_RD_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] wd;
`endif

    assign accept = (state == IDLE) && gany && !rst;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (accept),
        .gnt     (gnt),
        .idx     (gidx),
        .any     (gany)
    );

    assign g_addr = bus.req_addr[int'(gidx)*REG_WIDTH +: REG_WIDTH];
    assign g_len  = bus.req_len[int'(gidx)*8 +: 8];

    // Byte accounting: accept up to len bytes, flag anything extra.
    always_comb begin
        take      = bus.eng_byte_done && (cnt < num_regs);
        extra     = bus.eng_byte_done && !take;
        rcv_next  = cnt + {7'd0, take};
        burst_err = (rcv_next != num_regs) || ovf || extra;
    end

    // Scheduler FSM with registered engine and stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_id     <= '0;
            start_addr <= '0;
            num_regs   <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            gcnt       <= '0;
            new_cmd    <= 1'b0;
            abort_q    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_id      <= '0;
            rd_last    <= 1'b0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_err   <= 1'b0;
`ifdef SPI_RD_TIMEOUT_EN
            wd         <= '0;
`endif
        end else begin
            new_cmd    <= 1'b0;
            abort_q    <= 1'b0;
            rd_valid   <= 1'b0;
            done_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        lat_id <= gidx;
                        if (g_len == 8'd0) begin
                            done_valid <= 1'b1;
                            done_id    <= gidx;
                            done_err   <= 1'b1;
                        end else begin
                            start_addr <= g_addr;
                            num_regs   <= g_len;
                            new_cmd    <= 1'b1;
                            state      <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    ovf   <= 1'b0;
                    state <= BUSY;
`ifdef SPI_RD_TIMEOUT_EN
                    wd    <= '0;
`endif
                end
                BUSY: begin
                    if (take) begin
                        rd_valid <= 1'b1;
                        rd_data  <= bus.eng_data;
                        rd_id    <= lat_id;
                        rd_last  <= (cnt == num_regs - 8'd1);
                        cnt      <= rcv_next;
                    end
                    if (extra) begin
                        ovf <= 1'b1;
                    end
                    if (bus.eng_read_complete) begin
                        done_valid <= 1'b1;
                        done_id    <= lat_id;
                        done_err   <= burst_err;
                        gcnt       <= '0;
                        state      <= GAP;
                    end
`ifdef SPI_RD_TIMEOUT_EN
                    else if (wd == WDW'(TIMEOUT_CYC - 1)) begin
                        abort_q    <= 1'b1;
                        done_valid <= 1'b1;
                        done_id    <= lat_id;
                        done_err   <= 1'b1;
                        gcnt       <= '0;
                        state      <= GAP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                GAP: begin
                    if (gcnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gcnt <= gcnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready       = accept ? gnt : '0;
    assign bus.eng_new_command = new_cmd;
    assign bus.eng_start_addr  = start_addr;
    assign bus.eng_num_regs    = num_regs;
`ifdef SPI_RD_TIMEOUT_EN
    assign bus.eng_rstn        = ~rst & ~abort_q;
`else
    assign bus.eng_rstn        = ~rst;
`endif
    assign bus.rd_valid        = rd_valid;
    assign bus.rd_data         = rd_data;
    assign bus.rd_id           = rd_id;
    assign bus.rd_last         = rd_last;
    assign bus.done_valid      = done_valid;
    assign bus.done_id         = done_id;
    assign bus.done_err        = done_err;
    assign bus.busy            = (state != IDLE);

endmodule

// File: tb/tb_spi_read_scheduler.sv
// Directed bench for spi_read_scheduler: vector table plus
// round-robin, reset-in-burst and (optional) watchdog sequences.
module tb_spi_read_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    spi_read_scheduler_if #(.N_REQ(4), .REG_WIDTH(8)) bus();

    spi_read_scheduler #(
        .N_REQ(4), .REG_WIDTH(8), .GAP_CYCLES(2), .TIMEOUT_CYC(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         r;
        logic [7:0] addr;
        logic [7:0] len;
        int         nb;
        bit         sim;
        bit         err;
    } vec_t;

    vec_t v[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [7:0] a,
                           input logic [7:0] l);
        bus.req_addr[r*8 +: 8] = a;
        bus.req_len[r*8 +: 8]  = l;
    endtask

    initial begin
        int  gap_cnt;
        int  waited;
        int  gi;
        bit  seen;
        logic [3:0] exp_g;

        bus.req_valid = '0;
        bus.req_addr = '0;
        bus.req_len = '0;
        bus.eng_data = '0;
        bus.eng_byte_done = 1'b0;
        bus.eng_read_complete = 1'b0;

        v[0] = '{r: 0, addr: 8'h10, len: 8'd3,   nb: 3,   sim: 0, err: 0};
        v[1] = '{r: 1, addr: 8'h20, len: 8'd1,   nb: 1,   sim: 1, err: 0};
        v[2] = '{r: 2, addr: 8'h30, len: 8'd0,   nb: 0,   sim: 0, err: 1};
        v[3] = '{r: 3, addr: 8'h40, len: 8'd4,   nb: 2,   sim: 0, err: 1};
        v[4] = '{r: 1, addr: 8'h50, len: 8'd2,   nb: 3,   sim: 0, err: 1};
        v[5] = '{r: 2, addr: 8'hF0, len: 8'd255, nb: 255, sim: 1, err: 0};

        // reset state, requests must be ignored while rst=1
        bus.req_valid = 4'hF;
        tick();
        tick();
        chk("rst_eng_rstn", 32'(bus.eng_rstn), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_newcmd", 32'(bus.eng_new_command), 0);
        chk("rst_rdvalid", 32'(bus.rd_valid), 0);
        chk("rst_done", 32'(bus.done_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        bus.req_valid = '0;
        rst = 1'b0;
        #1;
        chk("rel_eng_rstn", 32'(bus.eng_rstn), 1);

        // table-driven single bursts
        for (int i = 0; i < 6; i++) begin
            bus.req_valid = '0;
            bus.req_valid[v[i].r] = 1'b1;
            set_req(v[i].r, v[i].addr, v[i].len);
            #1;
            chk("v_ready", 32'(bus.req_ready), 32'(1 << v[i].r));
            tick();
            bus.req_valid = '0;
            if (v[i].len == 8'd0) begin
                chk("z_done", 32'(bus.done_valid), 1);
                chk("z_id", 32'(bus.done_id), 32'(v[i].r));
                chk("z_err", 32'(bus.done_err), 1);
                chk("z_newcmd", 32'(bus.eng_new_command), 0);
                chk("z_busy", 32'(bus.busy), 0);
                continue;
            end
            chk("v_newcmd", 32'(bus.eng_new_command), 1);
            chk("v_addr", 32'(bus.eng_start_addr), 32'(v[i].addr));
            chk("v_len", 32'(bus.eng_num_regs), 32'(v[i].len));
            tick();
            chk("v_newcmd_pulse", 32'(bus.eng_new_command), 0);
            for (int k = 0; k < v[i].nb; k++) begin
                bus.eng_byte_done = 1'b1;
                bus.eng_data = 8'(v[i].addr + 8'(k));
                bus.eng_read_complete = v[i].sim && (k == v[i].nb - 1);
                tick();
                bus.eng_byte_done = 1'b0;
                bus.eng_read_complete = 1'b0;
                if (k < int'(v[i].len)) begin
                    chk("b_valid", 32'(bus.rd_valid), 1);
                    chk("b_data", 32'(bus.rd_data),
                        32'(8'(v[i].addr + 8'(k))));
                    chk("b_id", 32'(bus.rd_id), 32'(v[i].r));
                    chk("b_last", 32'(bus.rd_last),
                        32'(k == int'(v[i].len) - 1));
                end else begin
                    chk("b_drop", 32'(bus.rd_valid), 0);
                end
            end
            if (!v[i].sim) begin
                bus.eng_read_complete = 1'b1;
                tick();
                bus.eng_read_complete = 1'b0;
            end
            chk("d_valid", 32'(bus.done_valid), 1);
            chk("d_id", 32'(bus.done_id), 32'(v[i].r));
            chk("d_err", 32'(bus.done_err), 32'(v[i].err));
            chk("g_busy1", 32'(bus.busy), 1);
            tick();
            chk("g_busy2", 32'(bus.busy), 1);
            chk("g_newcmd", 32'(bus.eng_new_command), 0);
            chk("g_done_pulse", 32'(bus.done_valid), 0);
            tick();
            chk("g_idle", 32'(bus.busy), 0);
        end

        // round robin with all four requesters held valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 4; r++) set_req(r, 8'(8'h80 + 8'(r)), 8'd1);
        bus.req_valid = 4'hF;
        gap_cnt = 0;
        for (int g = 0; g < 5; g++) begin
            #1;
            waited = 0;
            while (bus.req_ready == 4'h0 && waited < 10) begin
                tick();
                gap_cnt++;
                waited++;
            end
            exp_g = 4'(1 << (g % 4));
            chk("rr_grant", 32'(bus.req_ready), 32'(exp_g));
            tick();
            gap_cnt++;
            chk("rr_newcmd", 32'(bus.eng_new_command), 1);
            chk("rr_addr", 32'(bus.eng_start_addr),
                32'(8'h80 + (g % 4)));
            if (g > 0) chk("rr_gap", 32'(gap_cnt), 3);
            tick();
            chk("rr_noready", 32'(bus.req_ready), 0);
            bus.eng_byte_done = 1'b1;
            bus.eng_read_complete = 1'b1;
            bus.eng_data = 8'h5A;
            tick();
            bus.eng_byte_done = 1'b0;
            bus.eng_read_complete = 1'b0;
            chk("rr_done", 32'(bus.done_valid), 1);
            chk("rr_done_id", 32'(bus.done_id), 32'(g % 4));
            chk("rr_last", 32'(bus.rd_last), 1);
            gap_cnt = 0;
        end
        bus.req_valid = '0;
        tick();
        tick();
        tick();

        // reset in the middle of a burst
        bus.req_valid = 4'b0001;
        set_req(0, 8'h77, 8'd4);
        tick();
        bus.req_valid = '0;
        tick();
        bus.eng_byte_done = 1'b1;
        bus.eng_data = 8'h11;
        tick();
        chk("mr_byte", 32'(bus.rd_valid), 1);
        rst = 1'b1;
        tick();
        bus.eng_byte_done = 1'b0;
        chk("mr_rdvalid", 32'(bus.rd_valid), 0);
        chk("mr_busy", 32'(bus.busy), 0);
        chk("mr_eng_rstn", 32'(bus.eng_rstn), 0);
        chk("mr_addr", 32'(bus.eng_start_addr), 0);
        rst = 1'b0;
        tick();
        chk("mr_nodone", 32'(bus.done_valid), 0);
        bus.req_valid = 4'b0010;
        set_req(1, 8'h33, 8'd1);
        tick();
        bus.req_valid = '0;
        chk("mr_newcmd", 32'(bus.eng_new_command), 1);
        chk("mr_newaddr", 32'(bus.eng_start_addr), 32'h33);
        tick();
        bus.eng_byte_done = 1'b1;
        bus.eng_read_complete = 1'b1;
        bus.eng_data = 8'h99;
        tick();
        bus.eng_byte_done = 1'b0;
        bus.eng_read_complete = 1'b0;
        chk("mr_done_err", 32'(bus.done_err), 0);
        chk("mr_rd_id", 32'(bus.rd_id), 1);
        tick();
        tick();

`ifdef SPI_RD_TIMEOUT_EN
        // silent engine: watchdog aborts after 64 BUSY cycles
        bus.req_valid = 4'b0100;
        set_req(2, 8'h44, 8'd2);
        tick();
        bus.req_valid = '0;
        tick();
        waited = 0;
        seen = 1'b0;
        while (!seen && waited < 200) begin
            tick();
            waited++;
            if (bus.eng_rstn == 1'b0) seen = 1'b1;
        end
        chk("to_seen", 32'(seen), 1);
        chk("to_cycles", 32'(waited), 64);
        chk("to_done", 32'(bus.done_valid), 1);
        chk("to_err", 32'(bus.done_err), 1);
        tick();
        chk("to_rstn_back", 32'(bus.eng_rstn), 1);
        tick();
        bus.req_valid = 4'b1000;
        set_req(3, 8'h66, 8'd1);
        tick();
        bus.req_valid = '0;
        chk("to_next", 32'(bus.eng_new_command), 1);
        chk("to_next_addr", 32'(bus.eng_start_addr), 32'h66);
`endif

        gi = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

endmodule
